// File: rtl/ysyx_22041211_mem_resp.sv
// Handshaked memory responder: accepts one load/store, waits LATENCY cycles, then performs
// the access against simulated physical memory with byte-lane placement and alignment checks.
package ysyx_22041211_mem_resp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  // Simulated physical memory behind the pmem_* entry points, word-addressed by byte address.
  logic [31:0] pmem [logic [31:0]];
  int unsigned pmem_reads;
  int unsigned pmem_writes;
  int unsigned pmem_bad_rmask;

  function automatic logic [31:0] pmem_read_task(input logic [31:0] addr, input logic [7:0] mask);
    logic [31:0] d;
    pmem_reads++;
    if (mask != 8'h0F) pmem_bad_rmask++;
    d = pmem.exists(addr) ? pmem[addr] : 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (!mask[i]) d[8*i +: 8] = 8'h00;
    end
    return d;
  endfunction

  function automatic void pmem_write_task(input logic [31:0] addr, input logic [31:0] data);
    pmem_writes++;
    pmem[addr] = data;
  endfunction
endpackage

module ysyx_22041211_mem_resp #(
  parameter int DATA_LEN = 32,
  parameter int LATENCY  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [DATA_LEN-1:0] req_addr_i,
  input  logic                req_wen_i,
  input  logic [1:0]          req_size_i,
  input  logic [DATA_LEN-1:0] req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_LEN-1:0] rsp_rdata_o,
  output logic                rsp_err_o
);
  import ysyx_22041211_mem_resp_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and a raised valid holds its payload until that edge.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [1:0]  size_q;

  logic [31:0] word_addr;
  logic [1:0]  off;
  logic        misaligned;
  logic [3:0]  strobe;
  logic [31:0] wdata_sh;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] o,
                                          input logic [1:0] sz);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {o, 3'b000};
    case (sz)
      2'd0:    r = {24'h0, sh[7:0]};
      2'd1:    r = {16'h0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  always_comb begin
    word_addr  = {addr_q[31:2], 2'b00};
    off        = addr_q[1:0];
    misaligned = 1'b1;
    strobe     = 4'b0000;
    case (size_q)
      2'd0: begin misaligned = 1'b0;        strobe = 4'b0001 << off; end
      2'd1: begin misaligned = off[0];      strobe = 4'b0011 << off; end
      2'd2: begin misaligned = (off != 0);  strobe = 4'b1111 << off; end
      default: ;
    endcase
    wdata_sh = wdata_q << {off, 3'b000};
  end

  assign req_ready_o = (state == ST_IDLE) && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid_i) begin
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          wen_q   <= req_wen_i;
          size_q  <= req_size_i;
          cnt     <= CNT_INIT;
          state   <= ST_BUSY;
        end
        ST_BUSY: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_valid_o <= 1'b1;
          state       <= ST_RESP;
          // Misaligned or illegal requests never touch memory.
          if (misaligned) begin
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
          end else if (wen_q) begin
            pmem_write_task(word_addr,
                            merge_bytes(pmem_read_task(word_addr, 8'h0F), wdata_sh, strobe));
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end else begin
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= extract(pmem_read_task(word_addr, 8'h0F), off, size_q);
          end
        end
        ST_RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22041211_mem_resp.sv
// Bench for ysyx_22041211_mem_resp: directed scenarios plus randomized traffic against a
// byte-level memory model; a LATENCY=1 instance covers back-to-back throughput.
module tb_ysyx_22041211_mem_resp;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: LATENCY=3
  logic         req_valid = 1'b0, req_wen = 1'b0, rsp_ready = 1'b0;
  logic [1:0]   req_size = 2'd0;
  logic [W-1:0] req_addr = '0, req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_err;
  logic [W-1:0] rsp_rdata;

  // Instance B: LATENCY=1
  logic         b_req_valid = 1'b0, b_req_wen = 1'b0, b_rsp_ready = 1'b0;
  logic [1:0]   b_req_size = 2'd0;
  logic [W-1:0] b_req_addr = '0, b_req_wdata = '0;
  logic         b_req_ready, b_rsp_valid, b_rsp_err;
  logic [W-1:0] b_rsp_rdata;

  ysyx_22041211_mem_resp #(.DATA_LEN(32), .LATENCY(3)) dut_a (
    .clk(clk), .rst(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wen_i(req_wen), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err));

  ysyx_22041211_mem_resp #(.DATA_LEN(32), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst_n), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_addr_i(b_req_addr), .req_wen_i(b_req_wen), .req_size_i(b_req_size), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err));

  int checks = 0;
  int failures = 0;

  logic [W-1:0] ref_mem [logic [31:0]];
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  // ---------------- reference model (byte-addressed view of memory) ----------------
  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
  endfunction

  function automatic logic mdl_err(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return (sz == 2'd3) || ((a % nb) != 0);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] r, ba, w;
    r = 0;
    if (mdl_err(a, sz)) return 32'h0;
    for (int i = 0; i < (1 << sz); i++) begin
      ba = a + i;
      w = ref_word(ba & ~32'h3);
      r = r | (((w >> (8 * (ba % 4))) & 32'hFF) << (8 * i));
    end
    return r;
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] ba, wa, w, sh;
    if (mdl_err(a, sz)) return;
    for (int i = 0; i < (1 << sz); i++) begin
      ba = a + i;
      wa = ba & ~32'h3;
      sh = 8 * (ba % 4);
      w = ref_word(wa);
      w = (w & ~(32'hFF << sh)) | (((d >> (8 * i)) & 32'hFF) << sh);
      ref_mem[wa] = w;
    end
  endtask

  task automatic preload(input logic [31:0] wa, input logic [31:0] d);
    ref_mem[wa] = d;
    ysyx_22041211_mem_resp_pkg::pmem[wa] = d;
  endtask

  function automatic logic [31:0] mem_now(input logic [31:0] wa);
    return ysyx_22041211_mem_resp_pkg::pmem.exists(wa) ? ysyx_22041211_mem_resp_pkg::pmem[wa] : 32'h0;
  endfunction

  // ---------------- driver tasks (instance A) ----------------
  task automatic start_req(input logic [31:0] a, input logic w, input logic [1:0] s,
                           input logic [31:0] d, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    ok = req_ready;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_addr = a; req_wen = w; req_size = s; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic wait_rsp(output int edges, output bit ok);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 60);
    edges = n - 1;
    ok = rsp_valid;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %0b required 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata: got %h required 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %0b required 0", rsp_err); end
    checks++; if (b_req_ready !== 1'b0) begin failures++; $display("FAIL reset_b_req_ready: got %0b required 0", b_req_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready: got %0b required 1", req_ready); end
  endtask

  task automatic test_word_load();
    int unsigned r0, w0;
    int edges;
    bit ok;
    preload(32'h80000004, 32'hDEADBEEF);
    r0 = ysyx_22041211_mem_resp_pkg::pmem_reads; w0 = ysyx_22041211_mem_resp_pkg::pmem_writes;
    start_req(32'h80000004, 1'b0, 2'd2, 32'h0, ok);
    if (!ok) return;
    wait_rsp(edges, ok);
    if (!ok) return;
    checks++; if (edges != 3) begin failures++; $display("FAIL load_latency: got %0d edges required 3", edges); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_data: got %h required deadbeef", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL word_load_err: got %0b required 0", rsp_err); end
    checks++; if (ysyx_22041211_mem_resp_pkg::pmem_reads - r0 != 1) begin failures++; $display("FAIL word_load_reads: got %0d required 1", ysyx_22041211_mem_resp_pkg::pmem_reads - r0); end
    checks++; if (ysyx_22041211_mem_resp_pkg::pmem_writes != w0) begin failures++; $display("FAIL word_load_writes: got %0d required 0", ysyx_22041211_mem_resp_pkg::pmem_writes - w0); end
    take_rsp();
  endtask

  task automatic test_byte_store_half_load();
    int unsigned r0, w0;
    int edges;
    bit ok;
    preload(32'h80000004, 32'h11223344);
    r0 = ysyx_22041211_mem_resp_pkg::pmem_reads; w0 = ysyx_22041211_mem_resp_pkg::pmem_writes;
    start_req(32'h80000006, 1'b1, 2'd0, 32'h5A5A5AAB, ok);
    if (!ok) return;
    mdl_store(32'h80000006, 2'd0, 32'h5A5A5AAB);
    wait_rsp(edges, ok);
    if (!ok) return;
    checks++; if (mem_now(32'h80000004) !== 32'h11AB3344) begin failures++; $display("FAIL byte_store_mem: got %h required 11ab3344", mem_now(32'h80000004)); end
    checks++; if (ref_word(32'h80000004) !== mem_now(32'h80000004)) begin failures++; $display("FAIL byte_store_model: got %h required %h", mem_now(32'h80000004), ref_word(32'h80000004)); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL byte_store_rsp: got %h/%0b required 0/0", rsp_rdata, rsp_err); end
    checks++; if (ysyx_22041211_mem_resp_pkg::pmem_reads - r0 != 1 || ysyx_22041211_mem_resp_pkg::pmem_writes - w0 != 1) begin
      failures++; $display("FAIL byte_store_calls: got reads=%0d writes=%0d required 1/1",
        ysyx_22041211_mem_resp_pkg::pmem_reads - r0, ysyx_22041211_mem_resp_pkg::pmem_writes - w0); end
    take_rsp();
    start_req(32'h80000006, 1'b0, 2'd1, 32'hFFFFFFFF, ok);
    if (!ok) return;
    wait_rsp(edges, ok);
    if (!ok) return;
    checks++; if (rsp_rdata !== 32'h000011AB) begin failures++; $display("FAIL half_load_data: got %h required 000011ab", rsp_rdata); end
    take_rsp();
  endtask

  task automatic test_misaligned();
    logic [31:0] a_tab [3] = '{32'h80000003, 32'h80000008, 32'h8000000A};
    logic        w_tab [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  s_tab [3] = '{2'd1, 2'd3, 2'd2};
    int unsigned r0, w0;
    int edges;
    bit ok;
    preload(32'h80000008, 32'h01020304);
    for (int i = 0; i < 3; i++) begin
      r0 = ysyx_22041211_mem_resp_pkg::pmem_reads; w0 = ysyx_22041211_mem_resp_pkg::pmem_writes;
      start_req(a_tab[i], w_tab[i], s_tab[i], 32'hA5A5A5A5, ok);
      if (!ok) return;
      wait_rsp(edges, ok);
      if (!ok) return;
      checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL misaligned_rsp[%0d]: got err=%0b rdata=%h required 1/0", i, rsp_err, rsp_rdata); end
      checks++; if (ysyx_22041211_mem_resp_pkg::pmem_reads != r0 || ysyx_22041211_mem_resp_pkg::pmem_writes != w0) begin
        failures++; $display("FAIL misaligned_calls[%0d]: got reads=%0d writes=%0d required 0/0", i,
          ysyx_22041211_mem_resp_pkg::pmem_reads - r0, ysyx_22041211_mem_resp_pkg::pmem_writes - w0); end
      take_rsp();
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL misaligned_idle[%0d]: req_ready=%0b required 1", i, req_ready); end
    end
    checks++; if (mem_now(32'h80000008) !== 32'h01020304) begin failures++; $display("FAIL misaligned_mem: got %h required 01020304", mem_now(32'h80000008)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int edges;
    bit ok;
    preload(32'h80000020, 32'hCAFEF00D);
    exp = mdl_load(32'h80000022, 2'd1);
    start_req(32'h80000022, 1'b0, 2'd1, 32'h0, ok);
    if (!ok) return;
    wait_rsp(edges, ok);
    if (!ok) return;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++; $display("FAIL backpressure_hold[%0d]: got v=%0b d=%h e=%0b rdy=%0b required 1/%h/0/0",
          i, rsp_valid, rsp_rdata, rsp_err, req_ready, exp); end
      @(negedge clk);
    end
    take_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL backpressure_release: got rdy=%0b v=%0b required 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid_busy();
    int unsigned r0, w0;
    bit ok;
    preload(32'h80000010, 32'h55667788);
    r0 = ysyx_22041211_mem_resp_pkg::pmem_reads; w0 = ysyx_22041211_mem_resp_pkg::pmem_writes;
    start_req(32'h80000010, 1'b1, 2'd2, 32'h99999999, ok);
    if (!ok) return;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL reset_busy_now: got v=%0b rdy=%0b required 0/0", rsp_valid, req_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_busy_release: req_ready=%0b required 1", req_ready); end
    repeat (5) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_busy_no_rsp: rsp_valid=%0b required 0", rsp_valid); end
    checks++; if (ysyx_22041211_mem_resp_pkg::pmem_writes != w0 || ysyx_22041211_mem_resp_pkg::pmem_reads != r0) begin
      failures++; $display("FAIL reset_busy_calls: got reads=%0d writes=%0d required 0/0",
        ysyx_22041211_mem_resp_pkg::pmem_reads - r0, ysyx_22041211_mem_resp_pkg::pmem_writes - w0); end
    checks++; if (mem_now(32'h80000010) !== 32'h55667788) begin failures++; $display("FAIL reset_busy_mem: got %h required 55667788", mem_now(32'h80000010)); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, got_exp;
    logic        w, got_err;
    logic [1:0]  s;
    int edges;
    bit ok;
    for (int i = 0; i < 16; i++) preload(32'h80000100 + 4 * i, $urandom);
    for (int i = 0; i < 24; i++) begin
      a = 32'h80000100 + $urandom_range(0, 63);
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      d = $urandom;
      exp_q.push_back(w ? 32'h0 : mdl_load(a, s));
      exp_err_q.push_back(mdl_err(a, s));
      if (w) mdl_store(a, s, d);
      start_req(a, w, s, d, ok);
      if (!ok) return;
      wait_rsp(edges, ok);
      if (!ok) return;
      got_exp = exp_q.pop_front();
      got_err = exp_err_q.pop_front();
      checks++; if (rsp_rdata !== got_exp || rsp_err !== got_err || edges != 3) begin
        failures++; $display("FAIL random_rsp[%0d] a=%h w=%0b s=%0d: got %h/%0b/%0d required %h/%0b/3",
          i, a, w, s, rsp_rdata, rsp_err, edges, got_exp, got_err); end
      take_rsp();
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem_now(32'h80000100 + 4 * i) !== ref_word(32'h80000100 + 4 * i)) begin
        failures++; $display("FAIL random_mem[%0d]: got %h required %h", i,
          mem_now(32'h80000100 + 4 * i), ref_word(32'h80000100 + 4 * i)); end
    end
    checks++; if (ysyx_22041211_mem_resp_pkg::pmem_bad_rmask != 0) begin failures++; $display("FAIL read_mask: got %0d bad masks required 0", ysyx_22041211_mem_resp_pkg::pmem_bad_rmask); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    logic [31:0] a, d, e;
    logic        w, ee;
    logic [1:0]  s;
    int sent, got, last_cyc, n;
    sent = 0; got = 0; last_cyc = -1; n = 0;
    for (int i = 0; i < 8; i++) preload(32'h80000200 + 4 * i, $urandom);
    exp_q.delete(); exp_err_q.delete();
    b_rsp_ready = 1'b1;
    while (got < N && n < 400) begin
      @(negedge clk); n++;
      if (b_rsp_valid) begin
        e = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        checks++; if (b_rsp_rdata !== e || b_rsp_err !== ee) begin
          failures++; $display("FAIL b2b_rsp[%0d]: got %h/%0b required %h/%0b", got, b_rsp_rdata, b_rsp_err, e, ee); end
        if (last_cyc >= 0) begin
          checks++; if (int'(cyc) - last_cyc != 3) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d cycles required 3", got, int'(cyc) - last_cyc); end
        end
        last_cyc = int'(cyc);
        got++;
      end
      if (b_req_ready && sent < N) begin
        a = 32'h80000200 + $urandom_range(0, 31);
        w = 1'($urandom_range(0, 1));
        s = 2'($urandom_range(0, 2));
        d = $urandom;
        exp_q.push_back(w ? 32'h0 : mdl_load(a, s));
        exp_err_q.push_back(mdl_err(a, s));
        if (w) mdl_store(a, s, d);
        b_req_valid = 1'b1; b_req_addr = a; b_req_wen = w; b_req_size = s; b_req_wdata = d;
        sent++;
      end else begin
        b_req_valid = 1'b0;
      end
    end
    b_req_valid = 1'b0;
    b_rsp_ready = 1'b0;
    checks++; if (got != N) begin failures++; $display("FAIL b2b_count: got %0d responses required %0d", got, N); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem_now(32'h80000200 + 4 * i) !== ref_word(32'h80000200 + 4 * i)) begin
        failures++; $display("FAIL b2b_mem[%0d]: got %h required %h", i,
          mem_now(32'h80000200 + 4 * i), ref_word(32'h80000200 + 4 * i)); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_load();
    test_byte_store_half_load();
    test_misaligned();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
